instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC SHALL be: default 32'h0000_0000, first fetch address after reset.
REQ-002 Port clk SHALL be: input, 1, sole clock, rising edge.
REQ-003 Port rst_n SHALL be: input, 1, asynchronous active-low reset.
REQ-004 Port imem_req SHALL be: output, 1, instruction-memory read request.
REQ-005 Port imem_addr SHALL be: output, 32, byte address of request.
REQ-006 Port imem_rvalid SHALL be: input, 1, read data valid.
REQ-007 Port imem_rdata SHALL be: input, 32, instruction word.
REQ-008 Port instr SHALL be: output, 32, held instruction to decode stage.
REQ-009 Port opcode SHALL be: output, 6, instr[31:26], feeds main control decoder.
REQ-010 Port instr_valid SHALL be: output, 1, instr/opcode/pc valid.
REQ-011 Port instr_ready SHALL be: input, 1, decode/execute accepts instr this cycle.
REQ-012 Port J SHALL be: input, 1, jump control from main decoder for presented instr.
REQ-013 Port B SHALL be: input, 1, branch control from main decoder for presented instr.
REQ-014 Port Zero SHALL be: input, 1, ALU zero flag for presented instr.
REQ-015 Port pc SHALL be: output, 32, address of presented instr.

Function
REQ-016 FSM SHALL have states IDLE, REQ, HOLD.
- IDLE -> REQ: the first clock edge after rst_n deasserts; imem_addr = RESET_PC.
- REQ: imem_req=1; imem_addr held stable until imem_rvalid=1.
- REQ -> HOLD: on imem_rvalid=1; capture imem_rdata into instr register and imem_addr into pc.
- HOLD: instr_valid=1; instr, opcode and pc held stable while instr_ready=0.
- HOLD -> REQ: on instr_ready=1; imem_addr loads next PC in the same edge.
REQ-017 Next PC SHALL be computed in the HOLD/accept cycle with priority J > (B & Zero) > sequential:
- J: {pc_plus4[31:28], instr[25:0], 2'b00}.
- B & Zero: pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00}), modulo 2^32.
- otherwise: pc_plus4 = pc + 4, modulo 2^32.
REQ-018 At most one memory request SHALL be outstanding; imem_rvalid outside REQ SHALL be ignored.
REQ-019 Fetch latency SHALL be one cycle from imem_rvalid to instr_valid; there SHALL be no bubble beyond the REQ state between accepted instructions.
REQ-020 J, B and Zero SHALL be sampled only when instr_valid & instr_ready; otherwise they SHALL be don't-care (X tolerated).
REQ-021 PC wrap SHALL apply: pc=32'hFFFF_FFFC sequential -> 32'h0000_0000.
REQ-022 imem_req and instr_valid SHALL never be asserted simultaneously.

Reset
REQ-023 While rst_n=0, the unit SHALL hold: state=IDLE, imem_req=0, imem_addr=RESET_PC, instr=0, opcode=0, instr_valid=0, pc=RESET_PC.
REQ-024 Reset asserted mid-request or mid-hold SHALL abort immediately; a late imem_rvalid after reset SHALL be ignored until the new REQ.

Structure
REQ-025 A shared package SHALL hold the FSM state enum, opcode constants (R-type 000000, lw 100011, sw 101011, beq 000100, j 000010) and the RESET_PC default.
REQ-026 One sub-module, npc_gen (combinational next-PC computation), SHALL be used; state and registers SHALL reside in instr_fetch_unit.

Verification
REQ-027 Sequential fetch: reset, rvalid in 2nd REQ cycle with 32'h8C010004, instr_ready=1, J=B=0 -> pc 0x0, then imem_addr=0x4, opcode=6'b100011.
REQ-028 Jump: pc=0x0000_0010, instr=32'h0800_0040, J=1 on accept -> next imem_addr=0x0000_0100.
REQ-029 Branch taken/not-taken: pc=0x20, instr=32'h1000_FFFE, B=1 -> Zero=1 gives next addr 0x1C; Zero=0 gives 0x24.
REQ-030 Backpressure: instr_ready=0 for 5 cycles in HOLD -> instr/pc/opcode stable, imem_req=0, no new address.
REQ-031 Wrap and reset: RESET_PC=32'hFFFF_FFFC, sequential accept -> next addr 0x0; rst_n low during REQ -> imem_req=0 asynchronously, refetch from RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Purpose : shared types and constants for the instruction fetch unit.
// Latency : n/a (declarations only).
// Backpr. : n/a.
//
// Contents: FSM state enum, primary opcode constants for the main decoder,
// and the default reset fetch address.
package instr_fetch_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_J     = 6'b000010;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_unit_npc_gen.sv
// Purpose : combinational next-PC selection (jump > taken branch > sequential).
// Latency : 0 cycles, purely combinational.
// Backpr. : none; the caller registers o_npc only when the instruction is accepted.
//
// Ports:
//   i_pc        address of the presented instruction
//   i_instr_idx instr[25:0] (jump index; low 16 bits double as branch offset)
//   i_j, i_b, i_zero  jump / branch / ALU-zero controls
//   o_npc       next fetch address, modulo 2^32
module npc_gen
    import instr_fetch_unit_pkg::*;
(
    input  logic [31:0] i_pc,
    input  logic [25:0] i_instr_idx,
    input  logic        i_j,
    input  logic        i_b,
    input  logic        i_zero,
    output logic [31:0] o_npc
);

    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_off;
    logic [31:0] w_jmp_tgt;
    logic [31:0] w_br_tgt;

    assign w_pc_plus4 = i_pc + 32'd4;
    // Word offset, sign-extended and scaled to bytes.
    assign w_br_off   = {{14{i_instr_idx[15]}}, i_instr_idx[15:0], 2'b00};
    assign w_br_tgt   = w_pc_plus4 + w_br_off;
    // Jump stays inside the 256 MB region of the delay-slot address.
    assign w_jmp_tgt  = {w_pc_plus4[31:28], i_instr_idx, 2'b00};

    always_comb begin
        o_npc = w_pc_plus4;
        if (i_j) begin
            o_npc = w_jmp_tgt;
        end else if (i_b && i_zero) begin
            o_npc = w_br_tgt;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Purpose : single-outstanding instruction fetch with hold register toward decode.
// Latency : instr_valid one cycle after imem_rvalid; REQ re-entered on the accept edge.
// Backpr. : instr_ready=0 holds instr/opcode/pc and suppresses new requests.
//
// Ports:
//   clk, rst_n              clock (rising edge) and async active-low reset
//   imem_req/imem_addr      read request and byte address to instruction memory
//   imem_rvalid/imem_rdata  read response (only honoured while in REQ)
//   instr/opcode/pc         presented instruction, its opcode and its address
//   instr_valid/instr_ready hand-shake with decode/execute
//   J, B, Zero              next-PC controls, sampled only on accept
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        J,
    input  logic        B,
    input  logic        Zero,
    output logic [31:0] pc
);

    fetch_state_t r_state;
    logic         r_imem_req;
    logic [31:0]  r_imem_addr;
    logic [31:0]  r_instr;
    logic [31:0]  r_pc;
    logic         r_instr_valid;
    logic [31:0]  w_npc;

    npc_gen u_npc_gen (
        .i_pc        (r_pc),
        .i_instr_idx (r_instr[25:0]),
        .i_j         (J),
        .i_b         (B),
        .i_zero      (Zero),
        .o_npc       (w_npc)
    );

    // All outputs come straight from registers, so reset clears them
    // asynchronously and req/valid can never glitch together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_imem_req    <= 1'b0;
            r_imem_addr   <= RESET_PC;
            r_instr       <= 32'h0;
            r_pc          <= RESET_PC;
            r_instr_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state     <= REQ;
                    r_imem_req  <= 1'b1;
                    r_imem_addr <= RESET_PC;
                end
                REQ: begin
                    if (imem_rvalid) begin
                        r_state       <= HOLD;
                        r_imem_req    <= 1'b0;
                        r_instr       <= imem_rdata;
                        r_pc          <= r_imem_addr;
                        r_instr_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    // rvalid is ignored here: nothing is outstanding.
                    if (instr_ready) begin
                        r_state       <= REQ;
                        r_imem_req    <= 1'b1;
                        r_imem_addr   <= w_npc;
                        r_instr_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state       <= IDLE;
                    r_imem_req    <= 1'b0;
                    r_instr_valid <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_imem_addr;
    assign instr       = r_instr;
    assign opcode      = r_instr[31:26];
    assign instr_valid = r_instr_valid;
    assign pc          = r_pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Purpose : self-checking bench for instr_fetch_unit (directed + random fetches).
// Latency : n/a.
// Backpr. : random instr_ready stalls with spurious rvalid during hold.
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic        instr_ready;
    logic        J, B, Zero;
    logic [31:0] pc;

    // Second instance with a reset address at the top of memory.
    logic        rst2_n;
    logic        req2;
    logic [31:0] addr2;
    logic        rvalid2;
    logic [31:0] rdata2;
    logic [31:0] instr2;
    logic [5:0]  opcode2;
    logic        valid2;
    logic        ready2;
    logic        j2, b2, z2;
    logic [31:0] pc2;

    int          n_checks;
    int          n_errors;
    logic [31:0] exp_addr;

    instr_fetch_unit u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .opcode      (opcode),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .J           (J),
        .B           (B),
        .Zero        (Zero),
        .pc          (pc)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk         (clk),
        .rst_n       (rst2_n),
        .imem_req    (req2),
        .imem_addr   (addr2),
        .imem_rvalid (rvalid2),
        .imem_rdata  (rdata2),
        .instr       (instr2),
        .opcode      (opcode2),
        .instr_valid (valid2),
        .instr_ready (ready2),
        .J           (j2),
        .B           (b2),
        .Zero        (z2),
        .pc          (pc2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference next-PC from the architectural rules, in plain arithmetic.
    function automatic logic [31:0] ref_npc(input logic [31:0] cur, input logic [31:0] ins,
                                            input logic j, input logic b, input logic z);
        logic [31:0] seq;
        int          off_words;
        seq = cur + 32'd4;
        if (j) return (seq & 32'hF000_0000) | ({6'b0, ins[25:0]} * 32'd4);
        if (b && z) begin
            off_words = int'($signed(ins[15:0]));
            return seq + 32'(off_words * 4);
        end
        return seq;
    endfunction

    // One full transaction: request, response after dly cycles, stall
    // cycles in hold, then accept with the given controls. Entered and left
    // at a negedge where a request is expected to be pending.
    task automatic fetch_one(input logic [31:0] d, input int dly, input int stall,
                             input logic j, input logic b, input logic z);
        logic [31:0] cur;
        cur = exp_addr;
        check("req_on", {31'b0, imem_req}, 32'd1);
        check("req_addr", imem_addr, cur);
        check("req_novalid", {31'b0, instr_valid}, 32'd0);
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            check("req_wait_on", {31'b0, imem_req}, 32'd1);
            check("req_wait_addr", imem_addr, cur);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = d;
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        check("hold_valid", {31'b0, instr_valid}, 32'd1);
        check("hold_noreq", {31'b0, imem_req}, 32'd0);
        check("hold_instr", instr, d);
        check("hold_opcode", {26'b0, opcode}, {26'b0, d[31:26]});
        check("hold_pc", pc, cur);
        for (int i = 0; i < stall; i++) begin
            instr_ready = 1'b0;
            J           = 1'($urandom_range(0, 1));
            B           = 1'($urandom_range(0, 1));
            Zero        = 1'($urandom_range(0, 1));
            imem_rvalid = 1'($urandom_range(0, 1));
            imem_rdata  = $urandom;
            @(negedge clk);
            check("stall_valid", {31'b0, instr_valid}, 32'd1);
            check("stall_noreq", {31'b0, imem_req}, 32'd0);
            check("stall_instr", instr, d);
            check("stall_opcode", {26'b0, opcode}, {26'b0, d[31:26]});
            check("stall_pc", pc, cur);
            check("stall_addr", imem_addr, cur);
        end
        imem_rvalid = 1'b0;
        instr_ready = 1'b1;
        J           = j;
        B           = b;
        Zero        = z;
        exp_addr    = ref_npc(cur, d, j, b, z);
        @(negedge clk);
        instr_ready = 1'b0;
        J           = 1'($urandom_range(0, 1));
        B           = 1'($urandom_range(0, 1));
        Zero        = 1'($urandom_range(0, 1));
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b0;
        rst2_n      = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        instr_ready = 1'b0;
        J = 1'b0; B = 1'b0; Zero = 1'b0;
        rvalid2 = 1'b0; rdata2 = 32'h0; ready2 = 1'b0;
        j2 = 1'b0; b2 = 1'b0; z2 = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_opcode", {26'b0, opcode}, 32'd0);
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_pc", pc, 32'h0);
        check("rst2_addr", addr2, 32'hFFFF_FFFC);
        check("rst2_pc", pc2, 32'hFFFF_FFFC);
        check("rst2_req", {31'b0, req2}, 32'd0);

        // Leave reset: first edge enters REQ at the reset address.
        rst_n    = 1'b1;
        exp_addr = 32'h0;
        @(negedge clk);

        // Sequential lw fetch, response in the second REQ cycle.
        fetch_one(32'h8C01_0004, 1, 0, 1'b0, 1'b0, 1'b0);
        // Jump to 0x10, then the jump from 0x10 to 0x100.
        fetch_one(32'h0800_0004, 0, 0, 1'b1, 1'b0, 1'b0);
        fetch_one(32'h0800_0040, 0, 0, 1'b1, 1'b0, 1'b0);
        check("jump_target", imem_addr, 32'h0000_0100);
        // Get to 0x20, branch taken to 0x1C.
        fetch_one(32'h0800_0008, 2, 0, 1'b1, 1'b0, 1'b0);
        fetch_one(32'h1000_FFFE, 0, 1, 1'b0, 1'b1, 1'b1);
        check("branch_taken", imem_addr, 32'h0000_001C);
        // Back to 0x20, branch not taken to 0x24.
        fetch_one(32'h0800_0008, 0, 0, 1'b1, 1'b0, 1'b0);
        fetch_one(32'h1000_FFFE, 0, 0, 1'b0, 1'b1, 1'b0);
        check("branch_not_taken", imem_addr, 32'h0000_0024);
        // Five cycles of backpressure.
        fetch_one({OPC_SW, 26'h0123456}, 0, 5, 1'b0, 1'b0, 1'b0);

        // Random traffic.
        for (int n = 0; n < 60; n++) begin
            fetch_one($urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                      1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a request; rvalid arriving late must be dropped.
        rst_n = 1'b0;
        #1;
        check("arst_req", {31'b0, imem_req}, 32'd0);
        check("arst_addr", imem_addr, 32'h0);
        check("arst_valid", {31'b0, instr_valid}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("refetch_req", {31'b0, imem_req}, 32'd1);
        check("refetch_addr", imem_addr, 32'h0);
        check("late_rvalid_ignored", {31'b0, instr_valid}, 32'd0);
        imem_rvalid = 1'b0;
        exp_addr    = 32'h0;
        fetch_one($urandom, 1, 0, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a hold.
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1234_5678;
        @(negedge clk);
        imem_rvalid = 1'b0;
        check("pre_rst_valid", {31'b0, instr_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("hold_rst_valid", {31'b0, instr_valid}, 32'd0);
        check("hold_rst_instr", instr, 32'h0);
        check("hold_rst_pc", pc, 32'h0);
        @(negedge clk);
        rst_n    = 1'b1;
        exp_addr = 32'h0;
        @(negedge clk);
        fetch_one(32'h8C01_0004, 0, 2, 1'b0, 1'b0, 1'b0);

        // PC wrap on the instance reset to 0xFFFF_FFFC.
        rst2_n = 1'b1;
        @(negedge clk);
        check("wrap_req", {31'b0, req2}, 32'd1);
        check("wrap_first_addr", addr2, 32'hFFFF_FFFC);
        rvalid2 = 1'b1;
        rdata2  = {OPC_RTYPE, 26'h0000020};
        @(negedge clk);
        rvalid2 = 1'b0;
        check("wrap_valid", {31'b0, valid2}, 32'd1);
        check("wrap_pc", pc2, 32'hFFFF_FFFC);
        ready2 = 1'b1;
        @(negedge clk);
        ready2 = 1'b0;
        check("wrap_next_addr", addr2, 32'h0);
        check("wrap_next_req", {31'b0, req2}, 32'd1);
        check("wrap_no_valid", {31'b0, valid2}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Request and valid must never coexist on either instance.
    always @(negedge clk) begin
        if (rst_n && imem_req && instr_valid) begin
            n_checks++;
            n_errors++;
            $display("FAIL req_valid_overlap: req=%0b valid=%0b at %0t", imem_req, instr_valid, $time);
        end
        if (rst2_n && req2 && valid2) begin
            n_checks++;
            n_errors++;
            $display("FAIL req_valid_overlap2: req=%0b valid=%0b at %0t", req2, valid2, $time);
        end
    end

endmodule
